instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_data;
   logic [31:0] ir_pc;

   modport master (
      output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - prefetching instruction fetch unit with redirect flush
// Optional fetch_count output when IFU_FETCH_COUNT_EN is defined.
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   instr_fetch_unit_if.master bus
`ifdef IFU_FETCH_COUNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_pc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [31:0]     r_data_mem [DEPTH];
   logic [31:0]     r_pc_mem   [DEPTH];
   logic            w_push;
   logic            w_pop;
   logic            w_redirect;
   logic            w_valid;
   logic            w_unused;

   assign w_redirect = bus.redirect_valid;
   assign w_valid    = (r_count != '0);
   // A redirect voids both the incoming word and any decode handshake this cycle.
   assign w_push     = (r_state == REQ) && bus.imem_ack && !w_redirect;
   assign w_pop      = w_valid && bus.ir_ready && !w_redirect;
   assign w_unused   = ^bus.redirect_pc[1:0];

   always_comb begin
      w_count_nxt = r_count;
      if (w_redirect)
         w_count_nxt = '0;
      else if (w_push && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (!w_redirect && (r_count < CW'(DEPTH)))
               w_state_nxt = REQ;
         end
         REQ: begin
            if (w_redirect)
               w_state_nxt = bus.imem_ack ? IDLE : DROP;
            else if (bus.imem_ack && !(w_count_nxt < CW'(DEPTH)))
               w_state_nxt = IDLE;
         end
         DROP: begin
            // The outstanding read still returns; its data belongs to the old path.
            if (!w_redirect && bus.imem_ack)
               w_state_nxt = REQ;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_pc     <= {RESET_PC[31:2], 2'b00};
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_redirect) begin
            r_pc     <= {bus.redirect_pc[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_pc     <= r_pc + 32'd4;
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_data_mem[r_wr_ptr] <= bus.imem_rdata;
         r_pc_mem[r_wr_ptr]   <= r_pc;
      end
   end

   assign bus.imem_req  = (r_state == REQ) || (r_state == DROP);
   assign bus.imem_addr = r_pc;
   assign bus.ir_valid  = w_valid;
   assign bus.ir_data   = w_valid ? r_data_mem[r_rd_ptr] : 32'h0;
   assign bus.ir_pc     = w_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;

`ifdef IFU_FETCH_COUNT_EN
   logic [31:0] r_fetch_count;

   always_ff @(posedge clock) begin
      if (reset)
         r_fetch_count <= 32'h0;
      else if (w_pop)
         r_fetch_count <= r_fetch_count + 32'd1;
   end

   assign fetch_count = r_fetch_count;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus_a ();
   instr_fetch_unit_if bus_b ();

`ifdef IFU_FETCH_COUNT_EN
   logic [31:0] fc_a;
   logic [31:0] fc_b;
`endif

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut_a (
      .clock (clk),
      .reset (rst),
      .bus   (bus_a)
`ifdef IFU_FETCH_COUNT_EN
      ,
      .fetch_count (fc_a)
`endif
   );

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
      .clock (clk),
      .reset (rst),
      .bus   (bus_b)
`ifdef IFU_FETCH_COUNT_EN
      ,
      .fetch_count (fc_b)
`endif
   );

   int   n_chk = 0;
   int   n_bad = 0;
   bit   auto_a = 1'b0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   int   acks_a = 0;

   function automatic logic [31:0] word_of(input logic [31:0] addr);
      return addr ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Memory model: ack arrives one cycle after req is first seen, then every cycle while req holds.
   task automatic tick();
      if (auto_a) begin
         bus_a.imem_ack   = bus_a.imem_req && prev_a;
         bus_a.imem_rdata = word_of(bus_a.imem_addr);
         if (bus_a.imem_ack) acks_a++;
      end
      prev_a = bus_a.imem_req;
      bus_b.imem_ack   = bus_b.imem_req && prev_b;
      bus_b.imem_rdata = word_of(bus_b.imem_addr);
      prev_b = bus_b.imem_req;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst                  = 1'b1;
      auto_a               = 1'b0;
      bus_a.imem_ack       = 1'b0;
      bus_a.redirect_valid = 1'b0;
      bus_a.redirect_pc    = 32'h0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] exp_b [4];

   initial begin
      rst                  = 1'b1;
      bus_a.imem_ack       = 1'b0;
      bus_a.imem_rdata     = 32'h0;
      bus_a.redirect_valid = 1'b0;
      bus_a.redirect_pc    = 32'h0;
      bus_a.ir_ready       = 1'b0;
      bus_b.imem_ack       = 1'b0;
      bus_b.imem_rdata     = 32'h0;
      bus_b.redirect_valid = 1'b0;
      bus_b.redirect_pc    = 32'h0;
      bus_b.ir_ready       = 1'b1;
      exp_b[0] = 32'hFFFF_FFF8;
      exp_b[1] = 32'hFFFF_FFFC;
      exp_b[2] = 32'h0000_0000;
      exp_b[3] = 32'h0000_0004;

      // Reset values and streaming with decode always ready
      rst = 1'b1;
      tick();
      tick();
      chk("rst_req", bus_a.imem_req, 32'(0));
      chk("rst_addr", bus_a.imem_addr, 32'h0);
      chk("rst_valid", bus_a.ir_valid, 32'(0));
      chk("rst_data", bus_a.ir_data, 32'h0);
      chk("rst_pc", bus_a.ir_pc, 32'h0);
      chk("rst_addr_b", bus_b.imem_addr, 32'hFFFF_FFF8);
`ifdef IFU_FETCH_COUNT_EN
      chk("rst_fcount", fc_a, 32'h0);
`endif
      rst            = 1'b0;
      auto_a         = 1'b1;
      bus_a.ir_ready = 1'b1;
      tick();
      chk("first_req", bus_a.imem_req, 32'(1));
      chk("first_addr", bus_a.imem_addr, 32'h0);
      tick();
      chk("no_early_valid", bus_a.ir_valid, 32'(0));
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("seq_valid", bus_a.ir_valid, 32'(1));
         chk("seq_pc", bus_a.ir_pc, 32'(4 * i));
         chk("seq_data", bus_a.ir_data, word_of(32'(4 * i)));
         chk("wrap_pc", bus_b.ir_pc, exp_b[i]);
         tick();
      end
`ifdef IFU_FETCH_COUNT_EN
      chk("fcount_4", fc_a, 32'd4);
`endif

      // Decode stalled: FIFO fills to DEPTH, fetching stops, then resumes at 16
      do_reset();
      bus_a.ir_ready = 1'b0;
      auto_a         = 1'b1;
      acks_a         = 0;
      repeat (12) tick();
      chk("full_pushes", 32'(acks_a), 32'd4);
      chk("full_req", bus_a.imem_req, 32'(0));
      chk("full_pc", bus_a.ir_pc, 32'h0);
      chk("full_valid", bus_a.ir_valid, 32'(1));
      bus_a.ir_ready = 1'b1;
      for (int k = 0; k < 5 && !bus_a.imem_req; k++) tick();
      chk("resume_req", bus_a.imem_req, 32'(1));
      chk("resume_addr", bus_a.imem_addr, 32'd16);

      // Redirect while a read is outstanding: late word discarded
      do_reset();
      bus_a.ir_ready = 1'b1;
      tick();
      chk("t3_req", bus_a.imem_req, 32'(1));
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_pc    = 32'h0000_0103;
      tick();
      bus_a.redirect_valid = 1'b0;
      chk("drop_req", bus_a.imem_req, 32'(1));
      chk("drop_addr", bus_a.imem_addr, 32'h0000_0100);
      tick();
      tick();
      bus_a.imem_ack   = 1'b1;
      bus_a.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus_a.imem_ack = 1'b0;
      chk("stale_valid", bus_a.ir_valid, 32'(0));
      chk("stale_addr", bus_a.imem_addr, 32'h0000_0100);
      chk("stale_req", bus_a.imem_req, 32'(1));
      bus_a.imem_ack   = 1'b1;
      bus_a.imem_rdata = word_of(32'h100);
      tick();
      bus_a.imem_ack = 1'b0;
      chk("redir_valid", bus_a.ir_valid, 32'(1));
      chk("redir_pc", bus_a.ir_pc, 32'h0000_0100);
      chk("redir_data", bus_a.ir_data, word_of(32'h100));

      // Redirect coincident with ack and decode handshake
      do_reset();
      bus_a.ir_ready = 1'b0;
      tick();
      bus_a.imem_ack   = 1'b1;
      bus_a.imem_rdata = word_of(32'h0);
      tick();
      chk("t4_valid", bus_a.ir_valid, 32'(1));
      bus_a.imem_rdata     = word_of(32'h4);
      bus_a.ir_ready       = 1'b1;
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_pc    = 32'h0000_0200;
      tick();
      bus_a.imem_ack       = 1'b0;
      bus_a.redirect_valid = 1'b0;
      bus_a.ir_ready       = 1'b0;
      chk("flush_valid", bus_a.ir_valid, 32'(0));
      chk("flush_req", bus_a.imem_req, 32'(0));
      chk("flush_addr", bus_a.imem_addr, 32'h0000_0200);
`ifdef IFU_FETCH_COUNT_EN
      chk("flush_fcount", fc_a, 32'h0);
`endif
      tick();
      chk("refetch_req", bus_a.imem_req, 32'(1));
      chk("refetch_addr", bus_a.imem_addr, 32'h0000_0200);

      // Reset pulse mid-request with two entries queued; trailing ack ignored
      do_reset();
      bus_a.ir_ready = 1'b0;
      tick();
      bus_a.imem_ack   = 1'b1;
      bus_a.imem_rdata = word_of(32'h0);
      tick();
      bus_a.imem_rdata = word_of(32'h4);
      tick();
      chk("t6_valid", bus_a.ir_valid, 32'(1));
      chk("t6_addr", bus_a.imem_addr, 32'h8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_valid", bus_a.ir_valid, 32'(0));
      chk("rstmid_req", bus_a.imem_req, 32'(0));
      chk("rstmid_addr", bus_a.imem_addr, 32'h0);
      tick();
      bus_a.imem_ack = 1'b0;
      chk("late_ack_valid", bus_a.ir_valid, 32'(0));
      chk("late_ack_req", bus_a.imem_req, 32'(1));
      chk("late_ack_addr", bus_a.imem_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
